alu16: RTL and testbench
========================

# alu16

16-bit arithmetic/logic unit for the 16-bit RISC processor datapath. It takes two operands and a 2-bit operation code and produces a 16-bit result plus zero and carry flags. Four operations are supported: add, subtract, logical shift and NAND. Outputs are registered on the single processor clock and feed the writeback and flag logic.

## Interface
Parameters:
- None. Data width is fixed at 16 bits.

Ports:
- `clk`: input, 1 bit. Processor clock; all state updates on the rising edge.
- `rst_n`: input, 1 bit. Reset, synchronous and active-low.
- `a`: input, 16 bits. Operand A; for shifts, the value being shifted.
- `b`: input, 16 bits. Operand B; for shifts, the shift control field.
- `op`: input, 2 bits. Operation select.
- `ans`: output, 16 bits. Registered result.
- `zero`: output, 1 bit. Registered flag; 1 when `ans` is 0.
- `carry`: output, 1 bit. Registered carry/borrow/shift-out flag.

## Operation
Operation select (`op`):
- **00 ADD**
  - `ans = (a + b)[15:0]`, unsigned.
  - `carry` = bit 16 of the 17-bit sum.
- **01 SUB**
  - `ans = (a - b)[15:0]`, two's complement wrap.
  - `carry` = borrow: 1 when `a < b` unsigned, else 0.
- **10 SHIFT**
  - `b[0]` selects direction: 0 = logical shift left (LSL), 1 = logical shift right (LSR).
  - `b[4:1]` = shift amount, 0–15. Zeros fill vacated bits.
  - `b[15:5]` are ignored; X/Z on these bits must not affect any output.
  - `carry` = last bit shifted out: `a[16-n]` for LSL by n, `a[n-1]` for LSR by n. `carry` = 0 when n = 0.
- **11 NAND**
  - `ans = ~(a & b)`, bitwise.
  - `carry` = 0.

Flags:
- `zero = (next ans == 16'h0000)` for every operation, computed from the same result that is registered into `ans`.
- No overflow or sign flag is produced.
- All result and flag logic is combinational from `a`, `b` and `op` into the output registers. No other internal state exists.

## Timing
- Outputs register on every rising `clk` edge; there is no enable. Latency is exactly 1 cycle from input to output.
- Reset: when `rst_n` = 0 at a rising edge, outputs take these values, overriding any computed result:
  - `ans` = 16'h0000
  - `zero` = 1
  - `carry` = 0
- The first valid result appears on the first edge after `rst_n` returns to 1.
- Reset asserted mid-stream discards the in-flight result.
- Back-to-back operations are supported, one per cycle, with no stall or handshake.
- Boundary cases:
  - ADD of 16'hFFFF + 16'h0001 gives `ans` = 0, `zero` = 1, `carry` = 1.
  - SUB with `a == b` gives `ans` = 0, `zero` = 1, `carry` = 0.
  - A shift by 15 leaves only one original bit in `ans`.

## Test plan
- **ADD**
  - a=4, b=3, op=00 → next cycle: `ans` = 7, `zero` = 0, `carry` = 0.
  - a=16'hFFF4, b=16'hFFAB, op=00 → `ans` = 16'hFF9F, `carry` = 1.
- **SUB**
  - a=4, b=3, op=01 → `ans` = 1, `carry` = 0.
  - a=4, b=5, op=01 → `ans` = 16'hFFFF, `carry` = 1.
  - a=7, b=7, op=01 → `ans` = 0, `zero` = 1, `carry` = 0.
- **SHIFT** (upper `b` bits driven X to confirm they are ignored)
  - a=4, b=16'bxxxx_xxxx_xxx0_0010, op=10 → LSL 1: `ans` = 8, `carry` = 0.
  - a=4, b=...0_0011, op=10 → LSR 1: `ans` = 2, `carry` = 0.
  - a=16'h8001, b=...0_0010 → LSL 1: `ans` = 16'h0002, `carry` = 1.
- **NAND**
  - a=4, b=3, op=11 → `ans` = 16'hFFFF, `carry` = 0.
  - a=16'hFFFF, b=16'hFFFF → `ans` = 0, `zero` = 1.
- **Reset**
  - Hold `rst_n` = 0 across an edge while an ADD with nonzero result is applied → `ans` = 0, `zero` = 1, `carry` = 0.
  - Release `rst_n` → the result appears on the following edge.

Source files
------------

// File: rtl/alu16.sv
// 16-bit ADD/SUB/SHIFT/NAND ALU with registered result, zero and carry flags.
// Latency: 1 cycle, one operation per clock; no handshake, never stalls.
module alu16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [1:0]  op,
    output logic [15:0] ans,
    output logic        zero,
    output logic        carry
);

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_SHIFT = 2'b10,
        OP_NAND  = 2'b11
    } op_t;

    logic [16:0] sum;
    logic [16:0] diff;
    logic [16:0] lsl_ext;
    logic [16:0] lsr_ext;
    logic [3:0]  shamt;
    logic        shdir;
    logic [15:0] res;
    logic        res_carry;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // Shifts see only b[4:0]; the extra guard bit catches the last bit shifted out.
    assign shdir   = b[0];
    assign shamt   = b[4:1];
    assign lsl_ext = {1'b0, a} << shamt;
    assign lsr_ext = {a, 1'b0} >> shamt;

    always_comb begin
        res       = 16'h0000;
        res_carry = 1'b0;
        case (op_t'(op))
            OP_ADD: begin
                res       = sum[15:0];
                res_carry = sum[16];
            end
            OP_SUB: begin
                res       = diff[15:0];
                res_carry = diff[16];
            end
            OP_SHIFT: begin
                if (shdir) begin
                    res       = lsr_ext[16:1];
                    res_carry = lsr_ext[0];
                end else begin
                    res       = lsl_ext[15:0];
                    res_carry = lsl_ext[16];
                end
            end
            OP_NAND: begin
                res       = ~(a & b);
                res_carry = 1'b0;
            end
            default: begin
                res       = 16'h0000;
                res_carry = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ans   <= 16'h0000;
            zero  <= 1'b1;
            carry <= 1'b0;
        end else begin
            ans   <= res;
            zero  <= (res == 16'h0000);
            carry <= res_carry;
        end
    end

endmodule

// File: tb/tb_alu16.sv
// Directed-vector bench for alu16: each task drives vectors and checks {ans, zero, carry}.
module tb_alu16;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [15:0] ans;
    logic        zero;
    logic        carry;

    int vectors;
    int miscompares;

    alu16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .op    (op),
        .ans   (ans),
        .zero  (zero),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge, then sample 1 time unit after the next rising edge.
    task automatic drive(input logic [15:0] ia, input logic [15:0] ib, input logic [1:0] iop);
        @(negedge clk);
        a  = ia;
        b  = ib;
        op = iop;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(16'h0004, 16'h0003, 2'b00);
        vectors++;
        if ({ans, zero, carry} !== {16'h0000, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got ans=%h z=%b c=%b, expected ans=0000 z=1 c=0", ans, zero, carry);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({ans, zero, carry} !== {16'h0007, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_release: got ans=%h z=%b c=%b, expected ans=0007 z=0 c=0", ans, zero, carry);
        end
    endtask

    task automatic test_add;
        drive(16'h0004, 16'h0003, 2'b00);
        vectors++;
        if ({ans, zero, carry} !== {16'h0007, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL add_small: got ans=%h z=%b c=%b, expected ans=0007 z=0 c=0", ans, zero, carry);
        end
        drive(16'hFFF4, 16'hFFAB, 2'b00);
        vectors++;
        if ({ans, zero, carry} !== {16'hFF9F, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL add_carry: got ans=%h z=%b c=%b, expected ans=ff9f z=0 c=1", ans, zero, carry);
        end
        drive(16'hFFFF, 16'h0001, 2'b00);
        vectors++;
        if ({ans, zero, carry} !== {16'h0000, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL add_wrap: got ans=%h z=%b c=%b, expected ans=0000 z=1 c=1", ans, zero, carry);
        end
    endtask

    task automatic test_sub;
        drive(16'h0004, 16'h0003, 2'b01);
        vectors++;
        if ({ans, zero, carry} !== {16'h0001, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL sub_pos: got ans=%h z=%b c=%b, expected ans=0001 z=0 c=0", ans, zero, carry);
        end
        drive(16'h0004, 16'h0005, 2'b01);
        vectors++;
        if ({ans, zero, carry} !== {16'hFFFF, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL sub_borrow: got ans=%h z=%b c=%b, expected ans=ffff z=0 c=1", ans, zero, carry);
        end
        drive(16'h0007, 16'h0007, 2'b01);
        vectors++;
        if ({ans, zero, carry} !== {16'h0000, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL sub_equal: got ans=%h z=%b c=%b, expected ans=0000 z=1 c=0", ans, zero, carry);
        end
    endtask

    task automatic test_shift;
        drive(16'h0004, {11'bx, 5'b00010}, 2'b10);
        vectors++;
        if ({ans, zero, carry} !== {16'h0008, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL lsl1: got ans=%h z=%b c=%b, expected ans=0008 z=0 c=0", ans, zero, carry);
        end
        drive(16'h0004, {11'bx, 5'b00011}, 2'b10);
        vectors++;
        if ({ans, zero, carry} !== {16'h0002, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL lsr1: got ans=%h z=%b c=%b, expected ans=0002 z=0 c=0", ans, zero, carry);
        end
        drive(16'h8001, {11'bx, 5'b00010}, 2'b10);
        vectors++;
        if ({ans, zero, carry} !== {16'h0002, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL lsl1_out: got ans=%h z=%b c=%b, expected ans=0002 z=0 c=1", ans, zero, carry);
        end
        drive(16'h0003, {11'bx, 5'b11110}, 2'b10);
        vectors++;
        if ({ans, zero, carry} !== {16'h8000, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL lsl15: got ans=%h z=%b c=%b, expected ans=8000 z=0 c=1", ans, zero, carry);
        end
        drive(16'hC000, {11'bx, 5'b11111}, 2'b10);
        vectors++;
        if ({ans, zero, carry} !== {16'h0001, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL lsr15: got ans=%h z=%b c=%b, expected ans=0001 z=0 c=1", ans, zero, carry);
        end
        drive(16'h1234, {11'bx, 5'b00001}, 2'b10);
        vectors++;
        if ({ans, zero, carry} !== {16'h1234, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL shift0: got ans=%h z=%b c=%b, expected ans=1234 z=0 c=0", ans, zero, carry);
        end
        drive(16'h0001, {11'bx, 5'b00011}, 2'b10);
        vectors++;
        if ({ans, zero, carry} !== {16'h0000, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL lsr_to_zero: got ans=%h z=%b c=%b, expected ans=0000 z=1 c=1", ans, zero, carry);
        end
    endtask

    task automatic test_nand;
        drive(16'h0004, 16'h0003, 2'b11);
        vectors++;
        if ({ans, zero, carry} !== {16'hFFFF, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL nand_ones: got ans=%h z=%b c=%b, expected ans=ffff z=0 c=0", ans, zero, carry);
        end
        drive(16'hFFFF, 16'hFFFF, 2'b11);
        vectors++;
        if ({ans, zero, carry} !== {16'h0000, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL nand_zero: got ans=%h z=%b c=%b, expected ans=0000 z=1 c=0", ans, zero, carry);
        end
        drive(16'hF0F0, 16'h0FF0, 2'b11);
        vectors++;
        if ({ans, zero, carry} !== {16'hFF0F, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL nand_mix: got ans=%h z=%b c=%b, expected ans=ff0f z=0 c=0", ans, zero, carry);
        end
    endtask

    task automatic test_back_to_back;
        // A carry-producing ADD must not leak its flag into the following NAND.
        drive(16'hFFFF, 16'h0002, 2'b00);
        vectors++;
        if ({ans, zero, carry} !== {16'h0001, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_add: got ans=%h z=%b c=%b, expected ans=0001 z=0 c=1", ans, zero, carry);
        end
        drive(16'h00FF, 16'h0F0F, 2'b11);
        vectors++;
        if ({ans, zero, carry} !== {16'hFFF0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_nand: got ans=%h z=%b c=%b, expected ans=fff0 z=0 c=0", ans, zero, carry);
        end
        drive(16'h0010, 16'h0020, 2'b01);
        vectors++;
        if ({ans, zero, carry} !== {16'hFFF0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_sub: got ans=%h z=%b c=%b, expected ans=fff0 z=0 c=1", ans, zero, carry);
        end
    endtask

    task automatic test_midstream_reset;
        drive(16'h0100, 16'h0023, 2'b00);
        vectors++;
        if ({ans, zero, carry} !== {16'h0123, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_pre: got ans=%h z=%b c=%b, expected ans=0123 z=0 c=0", ans, zero, carry);
        end
        rst_n = 1'b0;
        drive(16'hFFF4, 16'hFFAB, 2'b00);
        vectors++;
        if ({ans, zero, carry} !== {16'h0000, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_reset: got ans=%h z=%b c=%b, expected ans=0000 z=1 c=0", ans, zero, carry);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(16'h0004, 16'h0003, 2'b01);
        vectors++;
        if ({ans, zero, carry} !== {16'h0001, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_resume: got ans=%h z=%b c=%b, expected ans=0001 z=0 c=0", ans, zero, carry);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        a           = 16'h0000;
        b           = 16'h0000;
        op          = 2'b00;
        test_reset();
        test_add();
        test_sub();
        test_shift();
        test_nand();
        test_back_to_back();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
